// File: rtl/snake_body_ctrl.sv
// Snake game core: holds the body, moves it on step ticks, detects wall/self collisions and prey eating,
// negotiates legal prey positions with the upstream generator and answers renderer cell queries.
module snake_body_ctrl #(
    parameter int                       H_LOGIC_WIDTH = 5,
    parameter int                       V_LOGIC_WIDTH = 5,
    parameter logic [H_LOGIC_WIDTH-1:0] H_LOGIC_MAX   = 5'd31,
    parameter logic [V_LOGIC_WIDTH-1:0] V_LOGIC_MAX   = 5'd23,
    parameter int                       MAX_LEN       = 32,
    parameter int                       LEN_WIDTH     = 6,
    parameter int                       INIT_LEN      = 3,
    parameter int                       INIT_X        = 16,
    parameter int                       INIT_Y        = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     step,
    input  logic [1:0]               dir,
    input  logic [H_LOGIC_WIDTH-1:0] preyx,
    input  logic [V_LOGIC_WIDTH-1:0] preyy,
    output logic                     prey_new,
    output logic                     prey_ok,
    output logic [H_LOGIC_WIDTH-1:0] headx,
    output logic [V_LOGIC_WIDTH-1:0] heady,
    output logic [LEN_WIDTH-1:0]     length,
    output logic [7:0]               score,
    output logic                     alive,
    output logic                     busy,
    input  logic [H_LOGIC_WIDTH-1:0] qx,
    input  logic [V_LOGIC_WIDTH-1:0] qy,
    output logic                     qhit
);

    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_INIT,
        ST_PREY_REQ,
        ST_PREY_WAIT,
        ST_PREY_SCAN,
        ST_RUN,
        ST_CALC,
        ST_SCAN,
        ST_COMMIT,
        ST_DEAD
    } state_t;

    state_t                   state_q, state_d;
    logic [H_LOGIC_WIDTH-1:0] seg_x_q [MAX_LEN];
    logic [H_LOGIC_WIDTH-1:0] seg_x_d [MAX_LEN];
    logic [V_LOGIC_WIDTH-1:0] seg_y_q [MAX_LEN];
    logic [V_LOGIC_WIDTH-1:0] seg_y_d [MAX_LEN];
    logic [LEN_WIDTH-1:0]     length_q, length_d;
    logic [LEN_WIDTH-1:0]     idx_q, idx_d;
    logic [7:0]               score_q, score_d;
    logic                     alive_q, alive_d;
    logic                     prey_ok_q, prey_ok_d;
    logic                     prey_new_q, prey_new_d;
    logic                     busy_q, busy_d;
    logic                     qhit_q, qhit_d;
    logic [H_LOGIC_WIDTH-1:0] headx_q, headx_d;
    logic [V_LOGIC_WIDTH-1:0] heady_q, heady_d;
    logic [1:0]               cur_dir_q, cur_dir_d;
    logic [H_LOGIC_WIDTH-1:0] new_x_q, new_x_d;
    logic [V_LOGIC_WIDTH-1:0] new_y_q, new_y_d;
    logic                     eat_q, eat_d;
    logic [H_LOGIC_WIDTH-1:0] prey_x_q, prey_x_d;
    logic [V_LOGIC_WIDTH-1:0] prey_y_q, prey_y_d;

    logic [H_LOGIC_WIDTH-1:0] scan_x;
    logic [V_LOGIC_WIDTH-1:0] scan_y;
    logic [LEN_WIDTH-1:0]     scan_last;
    logic                     prey_range_bad;
    logic [H_LOGIC_WIDTH:0]   x_inc;
    logic [V_LOGIC_WIDTH:0]   y_inc;
    logic [H_LOGIC_WIDTH-1:0] calc_x;
    logic [V_LOGIC_WIDTH-1:0] calc_y;
    logic                     calc_wall;

    // Sequential scans share one segment mux; when not eating the tail vacates, so it is skipped.
    always_comb begin
        scan_x         = seg_x_q[idx_q[IDX_W-1:0]];
        scan_y         = seg_y_q[idx_q[IDX_W-1:0]];
        scan_last      = eat_q ? (length_q - LEN_WIDTH'(1)) : (length_q - LEN_WIDTH'(2));
        prey_range_bad = ({1'b0, preyx} > {1'b0, H_LOGIC_MAX}) ||
                         ({1'b0, preyy} > {1'b0, V_LOGIC_MAX});
    end

    // Candidate head one cell along cur_dir; the extra bit catches stepping past the far wall.
    always_comb begin
        x_inc     = {1'b0, seg_x_q[0]} + (H_LOGIC_WIDTH+1)'(1);
        y_inc     = {1'b0, seg_y_q[0]} + (V_LOGIC_WIDTH+1)'(1);
        calc_x    = seg_x_q[0];
        calc_y    = seg_y_q[0];
        calc_wall = 1'b0;
        case (cur_dir_q)
            2'b00: begin
                calc_wall = (seg_y_q[0] == '0);
                calc_y    = seg_y_q[0] - V_LOGIC_WIDTH'(1);
            end
            2'b01: begin
                calc_wall = (x_inc > {1'b0, H_LOGIC_MAX});
                calc_x    = x_inc[H_LOGIC_WIDTH-1:0];
            end
            2'b10: begin
                calc_wall = (y_inc > {1'b0, V_LOGIC_MAX});
                calc_y    = y_inc[V_LOGIC_WIDTH-1:0];
            end
            default: begin
                calc_wall = (seg_x_q[0] == '0);
                calc_x    = seg_x_q[0] - H_LOGIC_WIDTH'(1);
            end
        endcase
    end

    always_comb begin
        state_d    = state_q;
        seg_x_d    = seg_x_q;
        seg_y_d    = seg_y_q;
        length_d   = length_q;
        idx_d      = idx_q;
        score_d    = score_q;
        alive_d    = alive_q;
        prey_ok_d  = prey_ok_q;
        prey_new_d = 1'b0;
        headx_d    = headx_q;
        heady_d    = heady_q;
        cur_dir_d  = cur_dir_q;
        new_x_d    = new_x_q;
        new_y_d    = new_y_q;
        eat_d      = eat_q;
        prey_x_d   = prey_x_q;
        prey_y_d   = prey_y_q;

        case (state_q)
            ST_IDLE, ST_DEAD: begin
                if (start) begin
                    state_d = ST_INIT;
                end
            end
            ST_INIT: begin
                for (int i = 0; i < INIT_LEN; i++) begin
                    seg_x_d[i] = H_LOGIC_WIDTH'(INIT_X - i);
                    seg_y_d[i] = V_LOGIC_WIDTH'(INIT_Y);
                end
                length_d   = LEN_WIDTH'(INIT_LEN);
                headx_d    = H_LOGIC_WIDTH'(INIT_X);
                heady_d    = V_LOGIC_WIDTH'(INIT_Y);
                cur_dir_d  = 2'b01;
                score_d    = 8'd0;
                alive_d    = 1'b1;
                prey_ok_d  = 1'b0;
                prey_new_d = 1'b1;
                state_d    = ST_PREY_REQ;
            end
            ST_PREY_REQ: begin
                state_d = ST_PREY_WAIT;
            end
            ST_PREY_WAIT: begin
                idx_d   = '0;
                state_d = ST_PREY_SCAN;
            end
            ST_PREY_SCAN: begin
                if (prey_range_bad || (scan_x == preyx && scan_y == preyy)) begin
                    prey_new_d = 1'b1;
                    state_d    = ST_PREY_REQ;
                end else if (idx_q == length_q - LEN_WIDTH'(1)) begin
                    prey_ok_d = 1'b1;
                    prey_x_d  = preyx;
                    prey_y_d  = preyy;
                    state_d   = ST_RUN;
                end else begin
                    idx_d = idx_q + LEN_WIDTH'(1);
                end
            end
            ST_RUN: begin
                if (step) begin
                    // Reversing onto the neck is never allowed; opposite directions differ only in bit 1.
                    if ((dir ^ cur_dir_q) != 2'b10) begin
                        cur_dir_d = dir;
                    end
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                if (calc_wall) begin
                    alive_d = 1'b0;
                    state_d = ST_DEAD;
                end else begin
                    new_x_d = calc_x;
                    new_y_d = calc_y;
                    eat_d   = (calc_x == prey_x_q) && (calc_y == prey_y_q);
                    idx_d   = '0;
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (scan_x == new_x_q && scan_y == new_y_q) begin
                    alive_d = 1'b0;
                    state_d = ST_DEAD;
                end else if (idx_q == scan_last) begin
                    state_d = ST_COMMIT;
                end else begin
                    idx_d = idx_q + LEN_WIDTH'(1);
                end
            end
            ST_COMMIT: begin
                for (int i = 1; i < MAX_LEN; i++) begin
                    seg_x_d[i] = seg_x_q[i-1];
                    seg_y_d[i] = seg_y_q[i-1];
                end
                seg_x_d[0] = new_x_q;
                seg_y_d[0] = new_y_q;
                headx_d    = new_x_q;
                heady_d    = new_y_q;
                if (eat_q) begin
                    score_d = score_q + 8'd1;
                    if (length_q != LEN_WIDTH'(MAX_LEN)) begin
                        length_d = length_q + LEN_WIDTH'(1);
                    end
                    prey_ok_d  = 1'b0;
                    prey_new_d = 1'b1;
                    state_d    = ST_PREY_REQ;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_RUN) && (state_d != ST_IDLE) && (state_d != ST_DEAD);
    end

    // Renderer query: full parallel compare so it is valid regardless of what the FSM is doing.
    always_comb begin
        qhit_d = 1'b0;
        if (state_q != ST_IDLE) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                if ((LEN_WIDTH'(i) < length_q) && (seg_x_q[i] == qx) && (seg_y_q[i] == qy)) begin
                    qhit_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            length_q   <= '0;
            idx_q      <= '0;
            score_q    <= '0;
            alive_q    <= 1'b0;
            prey_ok_q  <= 1'b0;
            prey_new_q <= 1'b0;
            busy_q     <= 1'b0;
            qhit_q     <= 1'b0;
            headx_q    <= '0;
            heady_q    <= '0;
            cur_dir_q  <= 2'b01;
            new_x_q    <= '0;
            new_y_q    <= '0;
            eat_q      <= 1'b0;
            prey_x_q   <= '0;
            prey_y_q   <= '0;
        end else begin
            state_q    <= state_d;
            length_q   <= length_d;
            idx_q      <= idx_d;
            score_q    <= score_d;
            alive_q    <= alive_d;
            prey_ok_q  <= prey_ok_d;
            prey_new_q <= prey_new_d;
            busy_q     <= busy_d;
            qhit_q     <= qhit_d;
            headx_q    <= headx_d;
            heady_q    <= heady_d;
            cur_dir_q  <= cur_dir_d;
            new_x_q    <= new_x_d;
            new_y_q    <= new_y_d;
            eat_q      <= eat_d;
            prey_x_q   <= prey_x_d;
            prey_y_q   <= prey_y_d;
        end
    end

    always_ff @(posedge clk) begin
        seg_x_q <= seg_x_d;
        seg_y_q <= seg_y_d;
    end

    assign prey_new = prey_new_q;
    assign prey_ok  = prey_ok_q;
    assign headx    = headx_q;
    assign heady    = heady_q;
    assign length   = length_q;
    assign score    = score_q;
    assign alive    = alive_q;
    assign busy     = busy_q;
    assign qhit     = qhit_q;

endmodule
